mem_access_arbiter: RTL and testbench
=====================================

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 4, width of the RAM/MAR address.
REQ-002 Parameter: DATA_W, default 8, width of the RAM data word.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 manual_mode  input  1  high: only the loader port may be granted; low: both ports are eligible.
REQ-006 cpu_req, cpu_we  input  1 each  CPU access request; write when cpu_we=1, else read.
REQ-007 cpu_addr  input  ADDR_W  CPU address; cpu_wdata  input  DATA_W  CPU write data.
REQ-008 ld_req, ld_we  input  1 each  loader (switch/programmer) access request and write flag.
REQ-009 ld_addr  input  ADDR_W  loader address; ld_wdata  input  DATA_W  loader write data.
REQ-010 cpu_ack, ld_ack  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 rdata  output  DATA_W  read result, held until the next read completes.
REQ-012 mar_load  output  1  one-cycle strobe loading mar_addr into the MAR.
REQ-013 mar_addr  output  ADDR_W  latched address of the current transaction.
REQ-014 ram_we  output  1  one-cycle RAM write strobe; ram_wdata  output  DATA_W  latched write data.
REQ-015 ram_rdata  input  DATA_W  RAM output for the address currently held in the MAR.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ADDR, ACCESS, DONE; sequence IDLE->ADDR->ACCESS->DONE->IDLE, with no other transitions.
REQ-018 IDLE: an eligible request selects a winner; the winner's addr, we and wdata are latched; next state is ADDR. With no eligible request, the FSM stays in IDLE.
REQ-019 ADDR: mar_load=1 for exactly this cycle.
REQ-020 ACCESS: ram_we=latched we for exactly this cycle; if a read, rdata captures ram_rdata at the end of this cycle.
REQ-021 DONE: the winner's ack=1 for exactly this cycle; the other ack=0.
REQ-022 Latency: ack is asserted 3 cycles after the IDLE cycle in which the request was sampled; minimum spacing between successive grants is 4 cycles.
REQ-023 A requester holds req, we, addr and wdata until ack; changes after the latch cycle have no effect on the transaction in flight.
REQ-024 Dropping req mid-transaction does not abort the transaction; the transaction completes and ack still pulses.
REQ-025 A port is ineligible in IDLE when its req is low; the CPU port is also ineligible when manual_mode=1.
REQ-026 A manual_mode change mid-transaction takes effect only at the next IDLE arbitration.
REQ-027 Simultaneous eligible requests are resolved per REQ-033/REQ-034; exactly one port is granted.
REQ-028 Addresses pass through unmodified (no wrap or arithmetic); all ADDR_W values are legal.

Reset
REQ-029 rst high at a rising edge: state=IDLE; mar_load, ram_we, cpu_ack, ld_ack and busy are 0; mar_addr, ram_wdata and rdata are 0.
REQ-030 Reset mid-transaction aborts it; no ram_we or ack is issued for the aborted transaction.
REQ-031 The round-robin pointer resets to favour the CPU port.
REQ-032 rst has priority over every other input.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: on a tie, the port that did not win the last grant wins; the pointer updates on every grant.
REQ-034 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, with the CPU port winning every tie; no pointer state is implemented.

Verification
REQ-035 Loader write: manual_mode=1, ld_req=1, ld_we=1, ld_addr=4'hA, ld_wdata=8'h3C -> mar_load at cycle+1 with mar_addr=A; ram_we at cycle+2 with ram_wdata=3C; ld_ack at cycle+3.
REQ-036 CPU read: manual_mode=0, cpu_req=1, cpu_we=0, cpu_addr=4'h5, ram_rdata=8'h77 -> cpu_ack at cycle+3; rdata=77 and held until the next read; ram_we never asserted.
REQ-037 Tie, both ports requesting for 8 cycles: with ARB_ROUND_ROBIN_EN, grants alternate CPU, LD; without it, CPU wins both grants.
REQ-038 manual_mode=1 with only cpu_req=1 -> FSM stays in IDLE, busy=0, no ack.
REQ-039 rst pulsed in ACCESS during a write -> no ram_we, no ack; all outputs 0 on the next cycle; next request is served normally.
REQ-040 Requester drops req in ADDR -> transaction completes; ack still pulses at cycle+3.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Purpose : arbitrates CPU and loader access to a single-port RAM through a MAR,
//           one transaction at a time: IDLE -> ADDR -> ACCESS -> DONE -> IDLE.
// Latency : ack pulses 3 cycles after the IDLE cycle that sampled the request; grants >= 4 cycles apart.
// Ports   : clk, rst (sync, active-high); manual_mode; cpu_req/we/addr/wdata; ld_req/we/addr/wdata;
//           cpu_ack, ld_ack, rdata; mar_load, mar_addr; ram_we, ram_wdata; ram_rdata; busy.
// Config  : define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed CPU priority.
module mem_access_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              manual_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              cpu_ack,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mar_load,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   sel_ld_q;   // 1: loader owns the transaction in flight
  logic   we_q;
  logic   cpu_elig, ld_elig, grant, grant_ld;

`ifdef ARB_ROUND_ROBIN_EN
  logic   prio_ld_q;  // 1: loader wins the next tie
`endif

  always_comb begin
    state_d  = state_q;
    cpu_elig = cpu_req & ~manual_mode;
    ld_elig  = ld_req;
    grant    = cpu_elig | ld_elig;
`ifdef ARB_ROUND_ROBIN_EN
    grant_ld = ld_elig & (~cpu_elig | prio_ld_q);
`else
    grant_ld = ld_elig & ~cpu_elig;
`endif
    case (state_q)
      IDLE:    if (grant) state_d = ADDR;
      ADDR:    state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked by rst so a reset landing mid-transaction suppresses
  // the write and the ack already in the cycle it is asserted.
  always_comb begin
    busy     = (state_q != IDLE);
    mar_load = (state_q == ADDR) & ~rst;
    ram_we   = (state_q == ACCESS) & we_q & ~rst;
    cpu_ack  = (state_q == DONE) & ~sel_ld_q & ~rst;
    ld_ack   = (state_q == DONE) & sel_ld_q & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_ld_q  <= 1'b0;
      we_q      <= 1'b0;
      mar_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_ld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      // Latch the winner's request so later input changes cannot disturb it.
      if (state_q == IDLE && grant) begin
        sel_ld_q  <= grant_ld;
        we_q      <= grant_ld ? ld_we    : cpu_we;
        mar_addr  <= grant_ld ? ld_addr  : cpu_addr;
        ram_wdata <= grant_ld ? ld_wdata : cpu_wdata;
`ifdef ARB_ROUND_ROBIN_EN
        prio_ld_q <= ~grant_ld;
`endif
      end
      // The MAR was loaded in ADDR, so ram_rdata is valid for the whole ACCESS cycle.
      if (state_q == ACCESS && !we_q) rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       manual_mode;
  logic       cpu_req, cpu_we, ld_req, ld_we;
  logic [3:0] cpu_addr, ld_addr;
  logic [7:0] cpu_wdata, ld_wdata;
  logic       cpu_ack, ld_ack, mar_load, ram_we, busy;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [3:0] mar_addr;

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .manual_mode(manual_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .cpu_ack(cpu_ack), .ld_ack(ld_ack), .rdata(rdata),
    .mar_load(mar_load), .mar_addr(mar_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM + MAR environment driven only by the DUT's strobes.
  logic [7:0] ram [16];
  logic [3:0] mar_q;
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i * 37 + 5);
      mar_q <= 4'h0;
    end else begin
      if (mar_load) mar_q <= mar_addr;
      if (ram_we) ram[mar_q] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[mar_q];

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: transaction list, memory image and tie-break state.
  typedef struct {
    bit         port_ld;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
    int         t0;
  } item_t;

  item_t      q[$];
  logic [7:0] sb_mem [16];
  bit         prio_ld = 1'b0;
  logic [7:0] last_rd = 8'h00;

  // Monitor: every cycle, compare the DUT's outputs against the head transaction.
  item_t mit;
  bit    mhave;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst) begin
        chk("rst_strobes", {28'd0, mar_load, ram_we, cpu_ack, ld_ack}, 32'd0);
        q.delete();
        last_rd = 8'h00;
      end else begin
        mhave = (q.size() > 0);
        if (mhave) mit = q[0];
        chk("busy", busy, mhave && cyc >= mit.t0 + 1 && cyc <= mit.t0 + 3);
        chk("mar_load", mar_load, mhave && cyc == mit.t0 + 1);
        if (mhave && cyc == mit.t0 + 1) chk("mar_addr", mar_addr, mit.addr);
        chk("ram_we", ram_we, mhave && cyc == mit.t0 + 2 && mit.we);
        if (mhave && cyc == mit.t0 + 2 && mit.we) chk("ram_wdata", ram_wdata, mit.wdata);
        chk("cpu_ack", cpu_ack, mhave && cyc == mit.t0 + 3 && !mit.port_ld);
        chk("ld_ack", ld_ack, mhave && cyc == mit.t0 + 3 && mit.port_ld);
        if (mhave && cyc == mit.t0 + 3) begin
          if (!mit.we) last_rd = mit.rd;
          chk(mit.we ? "rdata_held" : "rdata", rdata, last_rd);
          void'(q.pop_front());
        end
      end
    end
  end

  // One arbitration round, entered just after a rising edge with the DUT idle.
  task automatic do_round(input bit mm, input bit cr, input bit cw, input logic [3:0] ca,
                          input logic [7:0] cd, input bit lr, input bit lw, input logic [3:0] la,
                          input logic [7:0] ldd, input bit drop, input bit abort);
    bit         ce, le, w_ld;
    item_t      it;
    logic [7:0] old;
    manual_mode = mm;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ld_req = lr;  ld_we = lw;  ld_addr = la;  ld_wdata = ldd;
    ce = cr && !mm;
    le = lr;
    if (!(ce || le)) begin
      repeat (4) @(posedge clk);
      #1;
    end else begin
      w_ld = le && (!ce || (RR_EN && prio_ld));
      prio_ld = !w_ld;
      it.port_ld = w_ld;
      it.we      = w_ld ? lw : cw;
      it.addr    = w_ld ? la : ca;
      it.wdata   = w_ld ? ldd : cd;
      it.rd      = sb_mem[it.addr];
      it.t0      = cyc;
      old        = sb_mem[it.addr];
      if (it.we) sb_mem[it.addr] = it.wdata;
      q.push_back(it);
      @(posedge clk);
      #1;
      if (drop) begin
        // Latched transaction must ignore everything from here on.
        if (w_ld) ld_req = 1'b0; else cpu_req = 1'b0;
        manual_mode = ~mm;
        cpu_we = ~cw; ld_we = ~lw;
        cpu_addr = 4'($urandom); ld_addr = 4'($urandom);
        cpu_wdata = 8'($urandom); ld_wdata = 8'($urandom);
      end
      if (abort) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_mem[it.addr] = old;
        prio_ld = 1'b0;
        chk("abort_mar_addr", mar_addr, 4'h0);
        chk("abort_ram_wdata", ram_wdata, 8'h00);
        chk("abort_rdata", rdata, 8'h00);
      end else begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sb_mem[i] = 8'(i * 37 + 5);
    rst = 1'b1;
    manual_mode = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
    ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = 4'h0;  ld_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_mar_addr", mar_addr, 4'h0);
    chk("reset_ram_wdata", ram_wdata, 8'h00);
    chk("reset_rdata", rdata, 8'h00);
    rst = 1'b0;

    // Loader write A <= 3C in manual mode.
    do_round(1, 0, 0, 4'h0, 8'h00, 1, 1, 4'hA, 8'h3C, 0, 0);
    // Preload 77 at address 5, then a CPU read of it.
    do_round(1, 0, 0, 4'h0, 8'h00, 1, 1, 4'h5, 8'h77, 0, 0);
    do_round(0, 1, 0, 4'h5, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0);
    // Writes in between keep rdata unchanged.
    do_round(0, 1, 1, 4'h2, 8'h91, 0, 0, 4'h0, 8'h00, 0, 0);
    // Two ties, then a CPU-only request in manual mode (no grant).
    do_round(0, 1, 1, 4'h3, 8'h11, 1, 1, 4'h4, 8'h22, 0, 0);
    do_round(0, 1, 0, 4'h3, 8'h00, 1, 0, 4'h4, 8'h00, 0, 0);
    do_round(1, 1, 1, 4'h7, 8'h55, 0, 0, 4'h0, 8'h00, 0, 0);
    // Reset landing in ACCESS of a write, then normal service.
    do_round(0, 1, 1, 4'h6, 8'hE1, 0, 0, 4'h0, 8'h00, 0, 1);
    do_round(0, 1, 0, 4'h6, 8'h00, 1, 0, 4'h9, 8'h00, 0, 0);
    // Requester drops req in ADDR; other inputs scrambled too.
    do_round(0, 0, 1, 4'h0, 8'h00, 1, 1, 4'hF, 8'hA5, 1, 0);
    do_round(0, 1, 0, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0);

    for (int n = 0; n < 250; n++) begin
      do_round(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
               4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 19) == 0));
    end

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
